// File: rtl/rv32_dmem_req_unit.sv
// rv32_dmem_req_unit: memory-stage load/store request initiator with alignment check and response tracking
module rv32_dmem_req_unit #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic [1:0]        rsp_addr_lo,
  output logic [2:0]        rsp_funct3,
  output logic              misalign,
  output logic              bus_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_e;
  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          lo_q, lo_d;
  logic [2:0]          f3_q, f3_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                misalign_q, misalign_d;
  logic                bus_err_q, bus_err_d;
  logic                is_b, is_h, is_w, undef, mis;
  logic [3:0]          be_calc;
  logic [31:0]         wd_calc;
  // width decode: low funct3 bits give the size, funct3[2] only selects zero-extension
  assign undef   = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
  assign is_b    = req_funct3[1:0] == 2'b00;
  assign is_h    = req_funct3[1:0] == 2'b01;
  assign is_w    = req_funct3 == 3'b010;
  assign mis     = undef || (is_h && req_addr[0]) || (is_w && req_addr[1:0] != 2'b00);
  assign be_calc = (is_b ? 4'b0001 : is_h ? 4'b0011 : 4'b1111) << req_addr[1:0];
  assign wd_calc = !req_store ? 32'h0 : is_b ? {4{req_wdata[7:0]}} : is_h ? {2{req_wdata[15:0]}} : req_wdata;
  assign req_ready   = state_q == IDLE;
  assign mem_valid   = state_q == REQ;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_be      = be_q;
  assign mem_wdata   = wdata_q;
  assign stall       = (state_q != IDLE) || (req_valid && !mis);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rdata_q;
  assign rsp_addr_lo = lo_q;
  assign rsp_funct3  = f3_q;
  assign misalign    = misalign_q;
  assign bus_err     = bus_err_q;
  // next state: accept/reject in IDLE, hold request until accepted, then await read data or time out
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    f3_d        = f3_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && mis) misalign_d = 1'b1;
        else if (req_valid) begin
          state_d = REQ;
          we_d    = req_store;
          addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          be_d    = be_calc;
          wdata_d = wd_calc;
          lo_d    = req_addr[1:0];
          f3_d    = req_funct3;
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_d = we_q ? IDLE : WAIT_RSP;
          cnt_d   = 4'd0;
        end
      end
      WAIT_RSP: begin
        if (mem_rvalid) begin
          rdata_d     = mem_rdata;
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (cnt_q == 4'(MAX_WAIT - 1)) begin
          rdata_d     = 32'h0;
          rsp_valid_d = 1'b1;
          bus_err_d   = 1'b1;
          state_d     = IDLE;
        end else cnt_d = cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and captured request/response registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      f3_q        <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      f3_q        <= f3_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
    end
  end
endmodule

// File: tb/tb_rv32_dmem_req_unit.sv
// tb_rv32_dmem_req_unit: directed and random load/store transactions checked against a size/offset reference model
module tb_rv32_dmem_req_unit;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        mem_valid, mem_ready = 1'b0, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall, rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_addr_lo;
  logic [2:0]  rsp_funct3;
  logic        misalign, bus_err;
  int checks = 0;
  int failures = 0;

  rv32_dmem_req_unit #(.ADDR_W(32), .MAX_WAIT(15)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr_lo(rsp_addr_lo),
    .rsp_funct3(rsp_funct3), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_mis(input logic [2:0] f, input logic [31:0] a);
    int sz;
    if (f == 3'b011 || f == 3'b110 || f == 3'b111) return 1'b1;
    sz = 1 << f[1:0];
    return (a % sz) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f, input logic [31:0] a);
    int sz;
    sz = 1 << f[1:0];
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wd(input bit st, input logic [2:0] f, input logic [31:0] wd);
    int sz;
    sz = 1 << f[1:0];
    if (!st) return 32'h0;
    if (sz == 1) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // one transaction; starts and ends just after a rising edge with the unit idle
  task automatic run_op(input bit st, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                        input int rdy_dly, input int rv_dly, input logic [31:0] rd);
    bit m;
    m = exp_mis(f, a);
    req_valid = 1'b1; req_store = st; req_funct3 = f; req_addr = a; req_wdata = wd;
    @(negedge clk);
    chk("accept_ready", 32'(req_ready), 32'd1);
    chk("accept_stall", 32'(stall), 32'(!m));
    step();
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
    if (m) begin
      @(negedge clk);
      chk("mis_pulse", 32'(misalign), 32'd1);
      chk("mis_no_mem", 32'(mem_valid), 32'd0);
      chk("mis_ready", 32'(req_ready), 32'd1);
      step();
      @(negedge clk);
      chk("mis_pulse_end", 32'(misalign), 32'd0);
      step();
      return;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      mem_ready = (i == rdy_dly);
      mem_rvalid = 1'($urandom);
      mem_rdata = $urandom;
      @(negedge clk);
      chk("req_valid", 32'(mem_valid), 32'd1);
      chk("req_we", 32'(mem_we), 32'(st));
      chk("req_addr", mem_addr, a & ~32'h3);
      chk("req_be", 32'(mem_be), 32'(exp_be(f, a)));
      chk("req_wdata", mem_wdata, exp_wd(st, f, wd));
      chk("req_stall", 32'(stall), 32'd1);
      chk("req_notready", 32'(req_ready), 32'd0);
      step();
    end
    mem_ready = 1'b0;
    if (st) begin
      mem_rvalid = 1'($urandom);
      @(negedge clk);
      chk("st_done_valid", 32'(mem_valid), 32'd0);
      chk("st_done_stall", 32'(stall), 32'd0);
      chk("st_done_ready", 32'(req_ready), 32'd1);
      chk("st_no_rsp", 32'(rsp_valid), 32'd0);
      step();
      mem_rvalid = 1'b0;
      return;
    end
    for (int i = 0; i < 15 && i <= rv_dly; i++) begin
      mem_rvalid = (i == rv_dly);
      mem_rdata = (i == rv_dly) ? rd : $urandom;
      @(negedge clk);
      chk("wait_stall", 32'(stall), 32'd1);
      chk("wait_novalid", 32'(mem_valid), 32'd0);
      chk("wait_norsp", 32'(rsp_valid), 32'd0);
      step();
    end
    mem_rvalid = 1'b0;
    mem_rdata = $urandom;
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_buserr", 32'(bus_err), 32'(rv_dly >= 15));
    chk("rsp_data", rsp_data, (rv_dly >= 15) ? 32'h0 : rd);
    chk("rsp_lo", 32'(rsp_addr_lo), 32'(a[1:0]));
    chk("rsp_f3", 32'(rsp_funct3), 32'(f));
    chk("rsp_stall", 32'(stall), 32'd0);
    step();
    @(negedge clk);
    chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
    chk("buserr_pulse_end", 32'(bus_err), 32'd0);
    step();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    step();
    resetn = 1'b1;
    step();
    run_op(1'b1, 3'b000, 32'h1003, 32'h000000AB, 0, 0, 32'h0);
    run_op(1'b1, 3'b001, 32'h2002, 32'h00001234, 3, 0, 32'h0);
    run_op(1'b0, 3'b010, 32'h3000, 32'h0, 0, 1, 32'hDEADBEEF);
    run_op(1'b0, 3'b010, 32'h3001, 32'h0, 0, 0, 32'h0);
    run_op(1'b1, 3'b001, 32'h3003, 32'h5555, 0, 0, 32'h0);
    run_op(1'b0, 3'b100, 32'h4001, 32'h0, 1, 15, 32'h0);
    run_op(1'b0, 3'b101, 32'h4002, 32'h0, 0, 14, 32'hCAFEF00D);
    run_op(1'b1, 3'b011, 32'h4000, 32'h1, 0, 0, 32'h0);
    // reset while a request is being presented
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h5000; req_wdata = 32'h11223344;
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_pre_valid", 32'(mem_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_valid_drop", 32'(mem_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    step();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1;
      @(negedge clk);
      chk("post_rst_norsp", 32'(rsp_valid), 32'd0);
      chk("post_rst_ready", 32'(req_ready), 32'd1);
      step();
    end
    mem_rvalid = 1'b0;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      run_op(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 15), $urandom);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
